// File: rtl/dct_mac_sequencer_pkg.sv
// Shared types and defaults for the DCT MAC sequencer slice.
package dct_mac_sequencer_pkg;

    localparam int unsigned N_TAPS_DEF   = 8;
    localparam int unsigned MULT_LAT_DEF = 1;
    localparam int unsigned IDX_W_DEF    = $clog2(N_TAPS_DEF);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } state_t;

    typedef logic [IDX_W_DEF-1:0] idx_t;

endpackage

// File: rtl/dct_mac_sequencer_if.sv
// Row-buffer / MAC datapath / zigzag-facing signals of the sequencer.
interface dct_mac_sequencer_if
    import dct_mac_sequencer_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] tap_idx;
    logic [IDX_W-1:0] coef_idx;
    logic             mult_en;
    logic             acc_en;
    logic             acc_load;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             busy;
    logic             done;

    // Sequencer side
    modport master (
        input  in_valid, out_ready,
        output in_ready, tap_idx, coef_idx, mult_en, acc_en, acc_load,
               out_valid, out_idx, busy, done
    );

    // Environment side (row buffer, datapath, downstream)
    modport slave (
        output in_valid, out_ready,
        input  in_ready, tap_idx, coef_idx, mult_en, acc_en, acc_load,
               out_valid, out_idx, busy, done
    );

endinterface

// File: rtl/dct_mac_sequencer_delay.sv
// Enable-gated shift register aligning control strobes with the multiplier pipeline.
module dct_mac_sequencer_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DEPTH];

    // Shift only on enabled cycles so the delay counts active cycles, not clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                sr[i] <= '0;
            end
        end else if (en) begin
            sr[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dct_mac_sequencer.sv
// Control FSM for one FDCT MAC datapath: N_TAPS taps per coefficient, N_TAPS coefficients per row.
module dct_mac_sequencer
    import dct_mac_sequencer_pkg::*;
#(
    parameter int unsigned N_TAPS   = N_TAPS_DEF,
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned IDX_W    = $clog2(N_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    dct_mac_sequencer_if.master bus
);

    localparam int unsigned DRN_W = $clog2(MULT_LAT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);
    localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(MULT_LAT - 1);

    state_t           state;
    logic [IDX_W-1:0] tap_cnt;
    logic [IDX_W-1:0] coef_cnt;
    logic [IDX_W-1:0] out_idx_q;
    logic [DRN_W-1:0] drn_cnt;
    logic             done_q;
    logic [1:0]       dly_in;
    logic [1:0]       dly_out;

    // Sequencer state, tap/coef/drain counters and handoff bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tap_cnt   <= '0;
            coef_cnt  <= '0;
            drn_cnt   <= '0;
            out_idx_q <= '0;
            done_q    <= 1'b0;
        end else if (ena) begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state    <= MAC;
                        tap_cnt  <= '0;
                        coef_cnt <= '0;
                    end
                end
                MAC: begin
                    if (tap_cnt == LAST_IDX) begin
                        state   <= DRAIN;
                        tap_cnt <= '0;
                        drn_cnt <= '0;
                    end else begin
                        tap_cnt <= tap_cnt + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    if (drn_cnt == LAST_DRN) begin
                        state     <= OUT;
                        out_idx_q <= coef_cnt;
                    end else begin
                        drn_cnt <= drn_cnt + DRN_W'(1);
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (coef_cnt == LAST_IDX) begin
                            state    <= IDLE;
                            coef_cnt <= '0;
                            done_q   <= 1'b1;
                        end else begin
                            state    <= MAC;
                            coef_cnt <= coef_cnt + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // {mult_en, first-tap tag} delayed to become {acc_en, acc_load}
    assign dly_in = {state == MAC, (state == MAC) && (tap_cnt == '0)};

    dct_mac_sequencer_delay #(
        .DEPTH (MULT_LAT),
        .WIDTH (2)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (ena),
        .din  (dly_in),
        .dout (dly_out)
    );

    // Strobes are suppressed while the clock enable is low; levels hold
    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == OUT);
    assign bus.mult_en   = (state == MAC) && ena;
    assign bus.acc_en    = dly_out[1] && ena;
    assign bus.acc_load  = dly_out[0] && ena;
    assign bus.done      = done_q && ena;
    assign bus.tap_idx   = tap_cnt;
    assign bus.coef_idx  = coef_cnt;
    assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Directed bench for dct_mac_sequencer (MULT_LAT=1 and MULT_LAT=3 instances).
module tb_dct_mac_sequencer;
    import dct_mac_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    int   checks = 0;
    int   errors = 0;

    dct_mac_sequencer_if #(.IDX_W(3)) bus  ();
    dct_mac_sequencer_if #(.IDX_W(3)) bus3 ();

    dct_mac_sequencer #(.N_TAPS(8), .MULT_LAT(1)) dut (
        .clk (clk), .rst (rst), .ena (ena), .bus (bus)
    );

    dct_mac_sequencer #(.N_TAPS(8), .MULT_LAT(3)) dut3 (
        .clk (clk), .rst (rst), .ena (ena), .bus (bus3)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        logic [15:0] exp_v;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_v = {1'b1, 6'b0, 9'b0};
        checks++;
        if ({bus.in_ready, bus.busy, bus.mult_en, bus.acc_en, bus.acc_load, bus.out_valid,
             bus.done, bus.tap_idx, bus.coef_idx, bus.out_idx} !== exp_v) begin
            errors++;
            $display("FAIL reset lat1 got %b exp %b", {bus.in_ready, bus.busy, bus.mult_en,
                     bus.acc_en, bus.acc_load, bus.out_valid, bus.done, bus.tap_idx,
                     bus.coef_idx, bus.out_idx}, exp_v);
        end
        checks++;
        if ({bus3.in_ready, bus3.busy, bus3.mult_en, bus3.acc_en, bus3.acc_load, bus3.out_valid,
             bus3.done, bus3.tap_idx, bus3.coef_idx, bus3.out_idx} !== exp_v) begin
            errors++;
            $display("FAIL reset lat3 got %b exp %b", {bus3.in_ready, bus3.busy, bus3.mult_en,
                     bus3.acc_en, bus3.acc_load, bus3.out_valid, bus3.done, bus3.tap_idx,
                     bus3.coef_idx, bus3.out_idx}, exp_v);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One full row, out_ready=1: period 10, mult 1-8, acc 2-9, out_valid 10, done 81
    task automatic test_full_row();
        logic [6:0] exp_v;
        logic [6:0] obs;
        int k;
        int u;
        for (int c = 0; c <= 81; c++) begin
            bus.in_valid  = (c == 0);
            bus.out_ready = 1'b1;
            @(negedge clk);
            k = 0;
            u = 0;
            exp_v = {1'b1, 5'b0, c == 81};
            if (c >= 1 && c <= 80) begin
                k = (c - 1) % 10;
                u = (c - 1) / 10;
                exp_v = {1'b0, 1'b1, k < 8, k >= 1 && k < 9, k == 1, k == 9, 1'b0};
            end
            obs = {bus.in_ready, bus.busy, bus.mult_en, bus.acc_en, bus.acc_load,
                   bus.out_valid, bus.done};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL full_row ctl c=%0d got %b exp %b", c, obs, exp_v);
            end
            if (exp_v[4]) begin
                checks++;
                if ({bus.tap_idx, bus.coef_idx} !== {3'(k), 3'(u)}) begin
                    errors++;
                    $display("FAIL full_row idx c=%0d got tap %0d coef %0d exp tap %0d coef %0d",
                             c, bus.tap_idx, bus.coef_idx, k, u);
                end
            end
            if (exp_v[1]) begin
                checks++;
                if (bus.out_idx !== 3'(u)) begin
                    errors++;
                    $display("FAIL full_row out_idx c=%0d got %0d exp %0d", c, bus.out_idx, u);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    // out_ready low for 5 cycles while coefficient 3 is presented (cycles 40-44)
    task automatic test_out_stall();
        for (int c = 0; c <= 86; c++) begin
            bus.in_valid  = (c == 0);
            bus.out_ready = !(c >= 40 && c <= 44);
            @(negedge clk);
            if (c >= 40 && c <= 45) begin
                checks++;
                if ({bus.out_valid, bus.mult_en, bus.out_idx} !== {1'b1, 1'b0, 3'd3}) begin
                    errors++;
                    $display("FAIL out_stall hold c=%0d got ov %b mult %b idx %0d exp 1 0 3",
                             c, bus.out_valid, bus.mult_en, bus.out_idx);
                end
            end
            if (c == 46) begin
                checks++;
                if ({bus.mult_en, bus.coef_idx, bus.tap_idx} !== {1'b1, 3'd4, 3'd0}) begin
                    errors++;
                    $display("FAIL out_stall resume got mult %b coef %0d tap %0d exp 1 4 0",
                             bus.mult_en, bus.coef_idx, bus.tap_idx);
                end
            end
            checks++;
            if (bus.done !== (c == 86)) begin
                errors++;
                $display("FAIL out_stall done c=%0d got %b exp %b", c, bus.done, c == 86);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Clock enable dropped every third cycle: taps 0..7 in order, 8 mult and 8 acc per coefficient
    task automatic test_ena_gaps();
        int  mcnt [8];
        int  acnt [8];
        int  etap [8];
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mcnt[i] = 0;
            acnt[i] = 0;
            etap[i] = 0;
        end
        for (int c = 0; c < 200 && !seen; c++) begin
            bus.in_valid  = (c == 0);
            bus.out_ready = 1'b1;
            ena = !(c >= 1 && (c % 3) == 0);
            @(negedge clk);
            if (bus.mult_en) begin
                checks++;
                if (bus.tap_idx !== 3'(etap[bus.coef_idx])) begin
                    errors++;
                    $display("FAIL ena_gaps tap c=%0d coef %0d got %0d exp %0d",
                             c, bus.coef_idx, bus.tap_idx, etap[bus.coef_idx]);
                end
                etap[bus.coef_idx]++;
                mcnt[bus.coef_idx]++;
            end
            if (bus.acc_en) acnt[bus.coef_idx]++;
            if (bus.done) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        ena = 1'b1;
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL ena_gaps done got %b exp 1 (timeout)", seen);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mcnt[i] != 8 || acnt[i] != 8) begin
                errors++;
                $display("FAIL ena_gaps count coef %0d got mult %0d acc %0d exp 8 8",
                         i, mcnt[i], acnt[i]);
            end
        end
    endtask

    // Reset during coef 2 tap 5 (cycle 26); new row accepted in the recovery cycle
    task automatic test_rst_mid_row();
        logic [15:0] obs;
        for (int c = 0; c <= 28; c++) begin
            bus.in_valid  = (c == 0) || (c == 27);
            bus.out_ready = 1'b1;
            rst = (c == 26);
            @(negedge clk);
            if (c == 26) begin
                checks++;
                if ({bus.mult_en, bus.coef_idx, bus.tap_idx} !== {1'b1, 3'd2, 3'd5}) begin
                    errors++;
                    $display("FAIL rst_mid pre got mult %b coef %0d tap %0d exp 1 2 5",
                             bus.mult_en, bus.coef_idx, bus.tap_idx);
                end
            end
            if (c == 27) begin
                obs = {bus.in_ready, bus.busy, bus.mult_en, bus.acc_en, bus.acc_load,
                       bus.out_valid, bus.done, bus.tap_idx, bus.coef_idx, bus.out_idx};
                checks++;
                if (obs !== {1'b1, 15'b0}) begin
                    errors++;
                    $display("FAIL rst_mid post got %b exp %b", obs, {1'b1, 15'b0});
                end
            end
            if (c == 28) begin
                checks++;
                if ({bus.busy, bus.mult_en, bus.acc_en, bus.coef_idx, bus.tap_idx, bus.done}
                    !== {1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL rst_mid restart got busy %b mult %b acc %b coef %0d tap %0d done %b exp 1 1 0 0 0 0",
                             bus.busy, bus.mult_en, bus.acc_en, bus.coef_idx, bus.tap_idx, bus.done);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // MULT_LAT=3 instance: period 12, acc_en lags mult_en by 3, done at 97
    task automatic test_mult_lat3();
        logic [5:0] exp_v;
        logic [5:0] obs;
        int k;
        for (int c = 0; c <= 97; c++) begin
            bus3.in_valid  = (c == 0);
            bus3.out_ready = 1'b1;
            @(negedge clk);
            k = 0;
            exp_v = {1'b0, 4'b0, c == 97};
            if (c >= 1 && c <= 96) begin
                k = (c - 1) % 12;
                exp_v = {1'b1, k < 8, k >= 3 && k < 11, k == 3, k == 11, 1'b0};
            end
            obs = {bus3.busy, bus3.mult_en, bus3.acc_en, bus3.acc_load, bus3.out_valid, bus3.done};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL lat3 ctl c=%0d got %b exp %b", c, obs, exp_v);
            end
            if (exp_v[1]) begin
                checks++;
                if (bus3.out_idx !== 3'((c - 1) / 12)) begin
                    errors++;
                    $display("FAIL lat3 out_idx c=%0d got %0d exp %0d", c, bus3.out_idx, (c - 1) / 12);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    // in_valid held across two rows: second row accepted in the done cycle
    task automatic test_back_to_back();
        logic [2:0] exp_v;
        logic [2:0] obs;
        logic       b;
        for (int c = 0; c <= 163; c++) begin
            bus.in_valid  = (c <= 81);
            bus.out_ready = 1'b1;
            @(negedge clk);
            b = (c >= 1 && c <= 80) || (c >= 82 && c <= 161);
            exp_v = {!b, b, (c == 81) || (c == 162)};
            obs = {bus.in_ready, bus.busy, bus.done};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL b2b ctl c=%0d got %b exp %b", c, obs, exp_v);
            end
            if (c == 82) begin
                checks++;
                if ({bus.mult_en, bus.coef_idx, bus.tap_idx} !== {1'b1, 3'd0, 3'd0}) begin
                    errors++;
                    $display("FAIL b2b start got mult %b coef %0d tap %0d exp 1 0 0",
                             bus.mult_en, bus.coef_idx, bus.tap_idx);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        ena            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus3.in_valid  = 1'b0;
        bus3.out_ready = 1'b1;
        test_reset();
        test_full_row();
        test_out_stall();
        test_ena_gaps();
        test_rst_mid_row();
        test_mult_lat3();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
